// File: rtl/spi_slave.sv
// Byte-oriented SPI slave (CPOL=1, CPHA=1) clocked directly by sck.
// Receives into rdata on rising edges and shifts tdata out on falling edges; bit order set by mlb.
module spi_slave (
  input  logic       sck,
  input  logic       rstb,
  input  logic       ss,
  input  logic       sdin,
  output logic       sdout,
  input  logic       ten,
  input  logic [7:0] tdata,
  input  logic       mlb,
  output logic       done,
  output logic [7:0] rdata
);

  logic [7:0] rsr;
  logic [7:0] rsr_next;
  logic [7:0] tsr;
  logic [2:0] cnt;
  logic       tx_bit;

  always_comb begin
    rsr_next = mlb ? {rsr[6:0], sdin} : {sdin, rsr[7:1]};
  end

  // Receive side: sample on the rising edge; cnt wraps to 0 on the 8th bit.
  always_ff @(posedge sck or negedge rstb) begin
    if (!rstb) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      rsr   <= 8'h00;
      rdata <= 8'h00;
      done  <= 1'b0;
      cnt   <= 3'd0;
    end else if (!ss) begin
      rsr <= rsr_next;
      if (cnt == 3'd7) begin
        rdata <= rsr_next;
        done  <= 1'b1;
        cnt   <= 3'd0;
      end else begin
        done <= 1'b0;
        cnt  <= cnt + 3'd1;
      end
    end
  end

  // Transmit side: cnt==0 on a falling edge means a new frame, so load the word.
  always_ff @(negedge sck or negedge rstb) begin
    if (!rstb) begin
      tsr <= 8'hFF;
    end else if (!ss) begin
      if (cnt == 3'd0) begin
        tsr <= tdata;
      end else if (mlb) begin
        tsr <= {tsr[6:0], 1'b0};
      end else begin
        tsr <= {1'b0, tsr[7:1]};
      end
    end
  end

  assign tx_bit = mlb ? tsr[7] : tsr[0];
  assign sdout  = (!ss && ten) ? tx_bit : 1'bz;

endmodule

// File: tb/tb_spi_slave.sv
// Directed self-checking bench for spi_slave: sck driven manually (idle high, 10 ns half-period).
// sdout carries a pull-up so a released (high-Z) line reads as 1.
module tb_spi_slave;

  logic       sck;
  logic       rstb;
  logic       ss;
  logic       sdin;
  wire        sdout;
  logic       ten;
  logic [7:0] tdata;
  logic       mlb;
  logic       done;
  logic [7:0] rdata;

  int total = 0;
  int bad   = 0;

  pullup (sdout);

  spi_slave dut (
    .sck   (sck),
    .rstb  (rstb),
    .ss    (ss),
    .sdin  (sdin),
    .sdout (sdout),
    .ten   (ten),
    .tdata (tdata),
    .mlb   (mlb),
    .done  (done),
    .rdata (rdata)
  );

  // One serial bit: falling edge, sample sdout mid-low and present sdin,
  // rising edge, sample done mid-high. Ends with sck high.
  task automatic sck_cycle(input logic bit_in, output logic sdout_seen, output logic done_seen);
    sck = 1'b0;
    #5;
    sdout_seen = sdout;
    sdin = bit_in;
    #5;
    sck = 1'b1;
    #5;
    done_seen = done;
    #5;
  endtask

  task automatic test_reset;
    rstb = 1'b0;
    #20;
    total++;
    if (rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata got=%h want=00", rdata); end
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++;
    if (sdout !== 1'b1) begin bad++; $display("FAIL reset_sdout_z got=%b want=released(1)", sdout); end
    rstb = 1'b1;
    #20;
    total++;
    if (rdata !== 8'h00) begin bad++; $display("FAIL release_rdata got=%h want=00", rdata); end
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL release_done got=%b want=0", done); end
  endtask

  task automatic test_msb_frame;
    logic [7:0] rx_seq;
    logic [7:0] tx_seq;
    logic       so;
    logic       dn;
    rx_seq = 8'b0101_0101;
    tx_seq = 8'b0111_1100;
    ten = 1'b1; mlb = 1'b1; tdata = 8'h7C;
    ss = 1'b0;
    #10;
    for (int i = 0; i < 8; i++) begin
      sck_cycle(rx_seq[7-i], so, dn);
      total++;
      if (so !== tx_seq[7-i]) begin bad++; $display("FAIL msb_sdout bit%0d got=%b want=%b", i, so, tx_seq[7-i]); end
    end
    total++;
    if (rdata !== 8'h55) begin bad++; $display("FAIL msb_rdata got=%h want=55", rdata); end
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL msb_done got=%b want=1", done); end
  endtask

  task automatic test_deselect;
    logic so;
    logic dn;
    ss = 1'b1;
    #10;
    total++;
    if (sdout !== 1'b1) begin bad++; $display("FAIL desel_sdout_z got=%b want=released(1)", sdout); end
    ten = 1'b0;
    #10;
    total++;
    if (sdout !== 1'b1) begin bad++; $display("FAIL ten0_sdout_z got=%b want=released(1)", sdout); end
    for (int i = 0; i < 3; i++) sck_cycle(1'b1, so, dn);
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL desel_done_hold got=%b want=1", done); end
    total++;
    if (rdata !== 8'h55) begin bad++; $display("FAIL desel_rdata_hold got=%h want=55", rdata); end
    // Selected but ten low: still released; raising ten drives tsr bit (0 after the frame).
    ss = 1'b0;
    #5;
    total++;
    if (sdout !== 1'b1) begin bad++; $display("FAIL sel_ten0_sdout_z got=%b want=released(1)", sdout); end
    ten = 1'b1;
    #5;
    total++;
    if (sdout !== 1'b0) begin bad++; $display("FAIL sel_ten1_sdout got=%b want=0", sdout); end
    ss = 1'b1;
    #10;
  endtask

  task automatic test_lsb_frame;
    logic [7:0] rx_seq;
    logic [7:0] tx_seq;
    logic       so;
    logic       dn;
    rx_seq = 8'b0101_0101;
    tx_seq = 8'b0000_1110;
    ten = 1'b1; mlb = 1'b0; tdata = 8'h70;
    ss = 1'b0;
    #10;
    for (int i = 0; i < 8; i++) begin
      sck_cycle(rx_seq[7-i], so, dn);
      total++;
      if (so !== tx_seq[7-i]) begin bad++; $display("FAIL lsb_sdout bit%0d got=%b want=%b", i, so, tx_seq[7-i]); end
      if (i == 0) begin
        total++;
        if (dn !== 1'b0) begin bad++; $display("FAIL lsb_done_fall got=%b want=0", dn); end
      end
    end
    total++;
    if (rdata !== 8'hAA) begin bad++; $display("FAIL lsb_rdata got=%h want=aa", rdata); end
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL lsb_done got=%b want=1", done); end
    ss = 1'b1;
    #10;
  endtask

  task automatic test_back_to_back;
    logic [7:0] tx_words [2];
    logic [7:0] rx_words [2];
    logic [7:0] tx;
    logic [7:0] rx;
    logic       so;
    logic       dn;
    logic       want_dn;
    tx_words[0] = 8'hA3; tx_words[1] = 8'h3C;
    rx_words[0] = 8'hC3; rx_words[1] = 8'h5A;
    ten = 1'b1; mlb = 1'b1;
    tdata = tx_words[0];
    ss = 1'b0;
    #10;
    for (int f = 0; f < 2; f++) begin
      tx = tx_words[f];
      rx = rx_words[f];
      tdata = tx;
      for (int i = 0; i < 8; i++) begin
        sck_cycle(rx[7-i], so, dn);
        want_dn = (i == 7);
        total++;
        if (so !== tx[7-i]) begin bad++; $display("FAIL b2b_sdout f%0d bit%0d got=%b want=%b", f, i, so, tx[7-i]); end
        total++;
        if (dn !== want_dn) begin bad++; $display("FAIL b2b_done f%0d bit%0d got=%b want=%b", f, i, dn, want_dn); end
      end
      total++;
      if (rdata !== rx) begin bad++; $display("FAIL b2b_rdata f%0d got=%h want=%h", f, rdata, rx); end
    end
    ss = 1'b1;
    #10;
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] tx;
    logic [7:0] rx;
    logic       so;
    logic       dn;
    tx = 8'h81;
    rx = 8'hA5;
    ten = 1'b1; mlb = 1'b1; tdata = tx;
    ss = 1'b0;
    #10;
    for (int i = 0; i < 4; i++) sck_cycle(1'b1, so, dn);
    rstb = 1'b0;
    #5;
    total++;
    if (rdata !== 8'h00) begin bad++; $display("FAIL midrst_rdata got=%h want=00", rdata); end
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b want=0", done); end
    rstb = 1'b1;
    #5;
    for (int i = 0; i < 8; i++) begin
      sck_cycle(rx[7-i], so, dn);
      total++;
      if (so !== tx[7-i]) begin bad++; $display("FAIL midrst_sdout bit%0d got=%b want=%b", i, so, tx[7-i]); end
    end
    total++;
    if (rdata !== 8'hA5) begin bad++; $display("FAIL midrst_frame_rdata got=%h want=a5", rdata); end
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL midrst_frame_done got=%b want=1", done); end
    ss = 1'b1;
    #10;
  endtask

  initial begin
    sck   = 1'b1;
    rstb  = 1'b0;
    ss    = 1'b1;
    sdin  = 1'b0;
    ten   = 1'b0;
    tdata = 8'h00;
    mlb   = 1'b1;
    test_reset();
    test_msb_frame();
    test_deselect();
    test_lsb_frame();
    test_back_to_back();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
